// File: rtl/rf_write_arbiter_if.sv
// Write-back bus between execution-unit requesters, the write arbiter and the register file ports.
// master = requester / register-file side, slave = arbiter.
interface rf_write_arbiter_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int NUM_REQ     = 4,
  parameter int WRITE_PORTS = 2
);
  logic [NUM_REQ-1:0]                     req_valid;
  logic [NUM_REQ-1:0]                     req_ready;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_data;
  logic [WRITE_PORTS-1:0]                 write_En;
  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] write_Addr;
  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] write_Data;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, write_En, write_Addr, write_Data
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, write_En, write_Addr, write_Data
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin write-back arbiter: up to WRITE_PORTS grants per cycle, never two to one non-zero register.
// Optional RF_WB_ZERO_DROP_EN: address-0 requests are accepted and dropped without using a port.
module rf_write_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int NUM_REQ     = 4,
  parameter int WRITE_PORTS = 2
) (
  input logic               clk,
  input logic               rst_n,
  rf_write_arbiter_if.slave wb
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]                       rr_ptr_reg;
  logic [PTR_W-1:0]                       rr_ptr_next;
  logic [PTR_W-1:0]                       idx;
  logic [NUM_REQ-1:0]                     port_gnt;
  logic [NUM_REQ-1:0]                     grant_ready;
  logic                                   conflict;
  int                                     grant_cnt;
  logic [WRITE_PORTS-1:0]                 en_next;
  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] addr_next;
  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] data_next;

  // Single scan from rr_ptr; port_gnt only holds requesters already visited, so the
  // conflict check only sees grants made earlier in this cycle's scan order.
  always_comb begin
    port_gnt    = '0;
    grant_ready = '0;
    en_next     = '0;
    addr_next   = '0;
    data_next   = '0;
    rr_ptr_next = rr_ptr_reg;
    grant_cnt   = 0;
    conflict    = 1'b0;
    idx         = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx      = PTR_W'((int'(rr_ptr_reg) + j) % NUM_REQ);
      conflict = 1'b0;
      for (int m = 0; m < NUM_REQ; m++) begin
        if (port_gnt[m] && (wb.req_addr[m] == wb.req_addr[idx]) && (wb.req_addr[idx] != '0)) begin
          conflict = 1'b1;
        end
      end
      if (wb.req_valid[idx]) begin
`ifdef RF_WB_ZERO_DROP_EN
        if (wb.req_addr[idx] == '0) begin
          grant_ready[idx] = 1'b1;
        end else
`endif
        if ((grant_cnt < WRITE_PORTS) && !conflict) begin
          grant_ready[idx] = 1'b1;
          port_gnt[idx]    = 1'b1;
          for (int k = 0; k < WRITE_PORTS; k++) begin
            if (k == grant_cnt) begin
              en_next[k]   = 1'b1;
              addr_next[k] = wb.req_addr[idx];
              data_next[k] = wb.req_data[idx];
            end
          end
          rr_ptr_next = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
          grant_cnt   = grant_cnt + 1;
        end
      end
    end
  end

  assign wb.req_ready = rst_n ? grant_ready : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Address/data only load on a grant so idle ports keep their last value.
  for (genvar gi = 0; gi < WRITE_PORTS; gi++) begin : g_port
    logic                  en_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_reg   <= 1'b0;
        addr_reg <= '0;
        data_reg <= '0;
      end else begin
        en_reg <= en_next[gi];
        if (en_next[gi]) begin
          addr_reg <= addr_next[gi];
          data_reg <= data_next[gi];
        end
      end
    end

    assign wb.write_En[gi]   = en_reg;
    assign wb.write_Addr[gi] = addr_reg;
    assign wb.write_Data[gi] = data_reg;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (4 requesters, 2 write ports); expectations follow RF_WB_ZERO_DROP_EN.
module tb_rf_write_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   grant_cnt[4];
  int   last_grant[4];
  int   max_gap[4];

  rf_write_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REQ(4), .WRITE_PORTS(2)) bus ();

  rf_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REQ(4), .WRITE_PORTS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_port(input string tag, input int k, input logic [5:0] a, input logic [31:0] d);
    check({tag, "_addr"}, 64'(bus.write_Addr[k]), 64'(a));
    check({tag, "_data"}, 64'(bus.write_Data[k]), 64'(d));
  endtask

  task automatic set_req(input int i, input logic v, input logic [5:0] a, input logic [31:0] d);
    bus.req_valid[i] = v;
    bus.req_addr[i]  = a;
    bus.req_data[i]  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'(i + 1), 32'hF0 + 32'(i));

    // Reset: ready suppressed even with requests pending, outputs cleared
    #2;
    check("rst_ready", 64'(bus.req_ready), 64'h0);
    check("rst_en", 64'(bus.write_En), 64'h0);
    check("rst_addr", 64'(bus.write_Addr), 64'h0);
    check("rst_data", 64'(bus.write_Data), 64'h0);
    bus.req_valid = '0;
    #10 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_en", 64'(bus.write_En), 64'h0);
    check("idle_addr", 64'(bus.write_Addr), 64'h0);
    check("idle_data", 64'(bus.write_Data), 64'h0);
    check("idle_ready", 64'(bus.req_ready), 64'h0);

    // Four distinct requests, two ports: two cycles of grants
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'(i + 1), 32'hA0 + 32'(i));
    #1 check("rr_c0_ready", 64'(bus.req_ready), 64'b0011);
    tick();
    check("rr_c0_en", 64'(bus.write_En), 64'b11);
    check_port("rr_c0_p0", 0, 6'd1, 32'hA0);
    check_port("rr_c0_p1", 1, 6'd2, 32'hA1);
    bus.req_valid[0] = 1'b0;
    bus.req_valid[1] = 1'b0;
    #1 check("rr_c1_ready", 64'(bus.req_ready), 64'b1100);
    tick();
    check("rr_c1_en", 64'(bus.write_En), 64'b11);
    check_port("rr_c1_p0", 0, 6'd3, 32'hA2);
    check_port("rr_c1_p1", 1, 6'd4, 32'hA3);
    bus.req_valid = '0;
    #1 check("rr_idle_ready", 64'(bus.req_ready), 64'h0);
    tick();
    check("rr_idle_en", 64'(bus.write_En), 64'b00);
    check_port("rr_hold_p0", 0, 6'd3, 32'hA2);

    // Same-register conflict: req1 deferred, req2 takes port1
    set_req(0, 1'b1, 6'd5, 32'h11);
    set_req(1, 1'b1, 6'd5, 32'h22);
    set_req(2, 1'b1, 6'd6, 32'h33);
    #1 check("cf_c0_ready", 64'(bus.req_ready), 64'b0101);
    tick();
    check("cf_c0_en", 64'(bus.write_En), 64'b11);
    check_port("cf_c0_p0", 0, 6'd5, 32'h11);
    check_port("cf_c0_p1", 1, 6'd6, 32'h33);
    bus.req_valid[0] = 1'b0;
    bus.req_valid[2] = 1'b0;
    #1 check("cf_c1_ready", 64'(bus.req_ready), 64'b0010);
    tick();
    check("cf_c1_en", 64'(bus.write_En), 64'b01);
    check_port("cf_c1_p0", 0, 6'd5, 32'h22);
    check_port("cf_c1_p1_hold", 1, 6'd6, 32'h33);
    bus.req_valid = '0;

    // Fairness: all four continuously valid for 8 cycles, pointer starts at 2
    for (int i = 0; i < 4; i++) begin
      set_req(i, 1'b1, 6'(i + 1), 32'hB0 + 32'(i));
      grant_cnt[i]  = 0;
      last_grant[i] = -1;
      max_gap[i]    = 0;
    end
    for (int c = 0; c < 8; c++) begin
      #1 check($sformatf("fair_c%0d_ready", c), 64'(bus.req_ready), (c % 2 == 0) ? 64'b1100 : 64'b0011);
      for (int i = 0; i < 4; i++) begin
        if (bus.req_ready[i]) begin
          grant_cnt[i]++;
          if (c - last_grant[i] > max_gap[i]) max_gap[i] = c - last_grant[i];
          last_grant[i] = c;
        end
      end
      tick();
      check($sformatf("fair_c%0d_en", c), 64'(bus.write_En), 64'b11);
    end
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fair_cnt%0d", i), 64'(grant_cnt[i]), 64'd4);
      check($sformatf("fair_gap%0d", i), 64'(max_gap[i]), 64'd2);
    end

    // Single grant to req3 returns the pointer to 0
    set_req(3, 1'b1, 6'd9, 32'h99);
    #1 check("wrap_ready", 64'(bus.req_ready), 64'b1000);
    tick();
    check("wrap_en", 64'(bus.write_En), 64'b01);
    check_port("wrap_p0", 0, 6'd9, 32'h99);
    bus.req_valid = '0;

    // Address 0 alongside a normal write
    set_req(1, 1'b1, 6'd0, 32'h55);
    set_req(2, 1'b1, 6'd7, 32'h77);
    #1 check("z_ready", 64'(bus.req_ready), 64'b0110);
    tick();
`ifdef RF_WB_ZERO_DROP_EN
    check("z_en", 64'(bus.write_En), 64'b01);
    check_port("z_p0", 0, 6'd7, 32'h77);
`else
    check("z_en", 64'(bus.write_En), 64'b11);
    check_port("z_p0", 0, 6'd0, 32'h55);
    check_port("z_p1", 1, 6'd7, 32'h77);
`endif
    bus.req_valid = '0;

    // Two address-0 requests in one cycle never conflict
    set_req(0, 1'b1, 6'd0, 32'h01);
    set_req(1, 1'b1, 6'd0, 32'h02);
    #1 check("zz_ready", 64'(bus.req_ready), 64'b0011);
    tick();
`ifdef RF_WB_ZERO_DROP_EN
    check("zz_en", 64'(bus.write_En), 64'b00);
`else
    check("zz_en", 64'(bus.write_En), 64'b11);
    check_port("zz_p0", 0, 6'd0, 32'h01);
    check_port("zz_p1", 1, 6'd0, 32'h02);
`endif
    bus.req_valid = '0;

    // Reset one cycle after a handshake: write dropped, pointer back to 0
    set_req(1, 1'b1, 6'd12, 32'hC1);
    #1 check("mr_ready", 64'(bus.req_ready), 64'b0010);
    tick();
    check("mr_en_pre", 64'(bus.write_En), 64'b01);
    check_port("mr_p0_pre", 0, 6'd12, 32'hC1);
    bus.req_valid[1] = 1'b0;
    set_req(0, 1'b1, 6'd13, 32'hD0);
    set_req(2, 1'b1, 6'd14, 32'hD2);
    set_req(3, 1'b1, 6'd15, 32'hD3);
    rst_n = 1'b0;
    #1;
    check("mr_en_async", 64'(bus.write_En), 64'b00);
    check("mr_addr_async", 64'(bus.write_Addr), 64'h0);
    check("mr_ready_rst", 64'(bus.req_ready), 64'h0);
    @(posedge clk);
    #4 rst_n = 1'b1;
    #1 check("mr_rel_ready", 64'(bus.req_ready), 64'b0101);
    tick();
    check("mr_rel_en", 64'(bus.write_En), 64'b11);
    check_port("mr_rel_p0", 0, 6'd13, 32'hD0);
    check_port("mr_rel_p1", 1, 6'd14, 32'hD2);
    bus.req_valid[0] = 1'b0;
    bus.req_valid[2] = 1'b0;
    #1 check("mr_last_ready", 64'(bus.req_ready), 64'b1000);
    tick();
    check("mr_last_en", 64'(bus.write_En), 64'b01);
    check_port("mr_last_p0", 0, 6'd15, 32'hD3);
    bus.req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
